// File: rtl/axi_gpu_burst_mem.sv
// AXI4 burst slave memory for a GPU node: INCR/FIXED bursts, strobes, SLVERR.
// Define AXI_BURST_WRAP_EN to also accept WRAP bursts.
module axi_gpu_burst_mem #(
  parameter int GPU_ID    = 27,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   S_AWID,
  input  logic [ADDR_W-1:0] S_AWADDR,
  input  logic [7:0]        S_AWLEN,
  input  logic [2:0]        S_AWSIZE,
  input  logic [1:0]        S_AWBURST,
  input  logic              S_AWVALID,
  output logic              S_AWREADY,
  input  logic [DATA_W-1:0] S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic              S_WLAST,
  input  logic              S_WVALID,
  output logic              S_WREADY,
  output logic [ID_W-1:0]   S_BID,
  output logic [1:0]        S_BRESP,
  output logic              S_BVALID,
  input  logic              S_BREADY,
  input  logic [ID_W-1:0]   S_ARID,
  input  logic [ADDR_W-1:0] S_ARADDR,
  input  logic [7:0]        S_ARLEN,
  input  logic [2:0]        S_ARSIZE,
  input  logic [1:0]        S_ARBURST,
  input  logic              S_ARVALID,
  output logic              S_ARREADY,
  output logic [ID_W-1:0]   S_RID,
  output logic [DATA_W-1:0] S_RDATA,
  output logic [1:0]        S_RRESP,
  output logic              S_RLAST,
  output logic              S_RVALID,
  input  logic              S_RREADY,
  output logic [15:0]       wr_done_cnt,
  output logic [15:0]       rd_done_cnt,
  output logic [5:0]        node_id
);

  localparam int NB    = DATA_W / 8;
  localparam int LOG2B = $clog2(NB);
  localparam int WORDS = MEM_BYTES / NB;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W:0] MEM_SZ = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [31:0] GID = GPU_ID;

`ifdef AXI_BURST_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [WORDS] = '{default: '0};

  function automatic logic legal(
    input logic [7:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic ok;
    ok = (size <= 3'(LOG2B)) && (burst != 2'b11);
    if (burst == 2'b10)
      ok = ok && WRAP_EN &&
           (len == 8'd1 || len == 8'd3 ||
            len == 8'd7 || len == 8'd15);
    return ok;
  endfunction

  // A borrow below BASE_ADDR makes the offset huge, so one compare suffices.
  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W:0] d;
    d = {1'b0, a} - {1'b0, BASE_ADDR};
    return d < MEM_SZ;
  endfunction

  function automatic logic [IDX_W-1:0] widx(
    input logic [ADDR_W-1:0] a
  );
    return IDX_W'(({1'b0, a} - {1'b0, BASE_ADDR}) >> LOG2B);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] a,
    input logic [7:0]        len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] step, mask, inc, nxt;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size)
           - ADDR_W'(1);
    inc  = a + step;
    unique case (1'b1)
      burst == 2'b00:
        nxt = a;
      burst == 2'b10 && WRAP_EN:
        nxt = (a & ~mask) | (inc & mask);
      default:
        nxt = inc;
    endcase
    return nxt;
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_e;

  wstate_e wstate, wstate_nx;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, w_ok;
  logic              aw_rdy, w_rdy, b_vld;
  logic              aw_fire, w_fire, b_fire;
  logic              w_hit, w_end;
  logic [15:0]       wr_cnt;

  always_ff @(posedge ACLK) begin
    if (ARESET) wstate <= W_IDLE;
    else        wstate <= wstate_nx;
  end

  always_comb begin
    wstate_nx = wstate;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    b_vld     = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        aw_rdy = 1'b1;
        if (S_AWVALID) wstate_nx = W_DATA;
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (S_WVALID && w_end) wstate_nx = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (S_BREADY) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  assign aw_fire = S_AWVALID & S_AWREADY;
  assign w_fire  = S_WVALID & S_WREADY;
  assign b_fire  = S_BVALID & S_BREADY;
  assign w_hit   = in_range(w_addr);
  assign w_end   = (w_cnt == w_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_ok    <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      if (aw_fire) begin
        w_id    <= S_AWID;
        w_addr  <= S_AWADDR;
        w_len   <= S_AWLEN;
        w_size  <= S_AWSIZE;
        w_burst <= S_AWBURST;
        w_cnt   <= '0;
        w_err   <= 1'b0;
        w_ok    <= legal(S_AWLEN, S_AWSIZE, S_AWBURST);
      end
      if (w_fire) begin
        w_cnt  <= w_cnt + 8'd1;
        w_addr <= next_addr(w_addr, w_len,
                            w_size, w_burst);
        if ((S_WLAST != w_end) || !w_hit)
          w_err <= 1'b1;
      end
      if (b_fire) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_fire && w_ok && w_hit) begin
      for (int b = 0; b < NB; b++)
        if (S_WSTRB[b])
          mem[widx(w_addr)][8*b +: 8] <= S_WDATA[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_e;

  rstate_e rstate, rstate_nx;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic              r_ok, r_err, r_last;
  logic [DATA_W-1:0] r_data;
  logic              ar_rdy, r_vld;
  logic              ar_fire, r_fire, r_load;
  logic [15:0]       rd_cnt;

  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_len, src_cnt;
  logic [2:0]        src_size;
  logic [1:0]        src_burst;
  logic              src_ok, src_hit;
  logic [DATA_W-1:0] src_word;

  always_ff @(posedge ACLK) begin
    if (ARESET) rstate <= R_IDLE;
    else        rstate <= rstate_nx;
  end

  always_comb begin
    rstate_nx = rstate;
    ar_rdy    = 1'b0;
    r_vld     = 1'b0;
    unique case (rstate)
      R_IDLE: begin
        ar_rdy = 1'b1;
        if (S_ARVALID) rstate_nx = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (S_RREADY && r_last) rstate_nx = R_IDLE;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // Beat 0 comes straight off the AR channel; later beats from the latched burst.
  always_comb begin
    src_addr  = r_addr;
    src_len   = r_len;
    src_size  = r_size;
    src_burst = r_burst;
    src_ok    = r_ok;
    src_cnt   = r_cnt + 8'd1;
    if (rstate == R_IDLE) begin
      src_addr  = S_ARADDR;
      src_len   = S_ARLEN;
      src_size  = S_ARSIZE;
      src_burst = S_ARBURST;
      src_ok    = legal(S_ARLEN, S_ARSIZE, S_ARBURST);
      src_cnt   = '0;
    end
  end

  assign src_hit  = src_ok && in_range(src_addr);
  assign src_word = mem[widx(src_addr)];
  assign ar_fire  = S_ARVALID & S_ARREADY;
  assign r_fire   = S_RVALID & S_RREADY;
  assign r_load   = ar_fire | (r_fire & ~r_last);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (ar_fire) begin
        r_id    <= S_ARID;
        r_len   <= S_ARLEN;
        r_size  <= S_ARSIZE;
        r_burst <= S_ARBURST;
        r_ok    <= src_ok;
      end
      if (r_load) begin
        r_cnt  <= src_cnt;
        r_addr <= next_addr(src_addr, src_len,
                            src_size, src_burst);
        r_data <= src_hit ? src_word : '0;
        r_err  <= !src_hit;
        r_last <= (src_cnt == src_len);
      end
      if (r_fire && r_last) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  // ---------------- outputs (forced low in reset) ----------------
  assign S_AWREADY   = aw_rdy & ~ARESET;
  assign S_WREADY    = w_rdy & ~ARESET;
  assign S_BVALID    = b_vld & ~ARESET;
  assign S_BID       = ARESET ? '0 : w_id;
  assign S_BRESP     = (ARESET || (w_ok && !w_err)) ? 2'b00 : 2'b10;
  assign S_ARREADY   = ar_rdy & ~ARESET;
  assign S_RVALID    = r_vld & ~ARESET;
  assign S_RID       = ARESET ? '0 : r_id;
  assign S_RDATA     = ARESET ? '0 : r_data;
  assign S_RRESP     = (ARESET || !r_err) ? 2'b00 : 2'b10;
  assign S_RLAST     = r_last & r_vld & ~ARESET;
  assign wr_done_cnt = ARESET ? '0 : wr_cnt;
  assign rd_done_cnt = ARESET ? '0 : rd_cnt;
  assign node_id     = GID[5:0];

endmodule

// File: tb/tb_axi_gpu_burst_mem.sv
// Directed bench for axi_gpu_burst_mem with a byte-array reference model.
`timescale 1ns/1ps
module tb_axi_gpu_burst_mem;

`ifdef AXI_BURST_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif
  localparam int MEMB = 8192;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic [3:0]  S_AWID, S_ARID, S_BID, S_RID;
  logic [31:0] S_AWADDR, S_ARADDR;
  logic [7:0]  S_AWLEN, S_ARLEN, S_WSTRB;
  logic [2:0]  S_AWSIZE, S_ARSIZE;
  logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
  logic        S_AWVALID, S_AWREADY, S_WLAST, S_WVALID, S_WREADY;
  logic        S_BVALID, S_BREADY, S_ARVALID, S_ARREADY;
  logic        S_RLAST, S_RVALID, S_RREADY;
  logic [63:0] S_WDATA, S_RDATA;
  logic [15:0] wr_done_cnt, rd_done_cnt;
  logic [5:0]  node_id;

  axi_gpu_burst_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN),
    .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt),
    .node_id(node_id)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int vectors = 0;
  int miscompares = 0;
  rbeat_t      exp_r[$];
  logic [5:0]  exp_b[$];
  logic [63:0] rlog[$];
  logic [1:0]  last_bresp = 2'b11;
  logic [15:0] exp_wr = 0, exp_rd = 0;
  bit          stall = 0;
  logic [63:0] stall_data = 0;
  logic [7:0]  mb [MEMB];
  logic [63:0] wbuf [16];
  logic [7:0]  sbuf [16];

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic bit legal_m(int len, int size, int burst);
    if (size > 3 || burst == 3) return 1'b0;
    if (burst == 2)
      return WRAP_ON && (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  function automatic int baddr(int a0, int len, int size, int burst, int i);
    int step, span, lo;
    step = 1 << size;
    span = (len + 1) * step;
    case (burst)
      0: return a0;
      2: begin
        lo = a0 - (a0 % span);
        return lo + ((a0 - lo + i * step) % span);
      end
      default: return a0 + i * step;
    endcase
  endfunction

  function automatic logic [63:0] mword(int a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[8*b +: 8] = mb[(a & ~7) + b];
    return w;
  endfunction

  function automatic logic sig(int k);
    case (k)
      0: return S_AWREADY;
      1: return S_WREADY;
      2: return S_BVALID;
      default: return S_ARREADY;
    endcase
  endfunction

  task automatic wait_sig(input int k, input string nm);
    int t = 0;
    @(negedge ACLK);
    while (!sig(k) && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    check(nm, sig(k), 1'b1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input int a0, input int len, input int size,
                          input int burst, input logic [3:0] id,
                          input int nsend);
    bit lg, err;
    int a;
    lg = legal_m(len, size, burst);
    err = !lg;
    for (int i = 0; i < nsend; i++) begin
      a = baddr(a0, len, size, burst, i);
      if (a >= MEMB) err = 1'b1;
      else if (lg)
        for (int b = 0; b < 8; b++)
          if (sbuf[i][b]) mb[(a & ~7) + b] = wbuf[i][8*b +: 8];
    end
    if (nsend == len + 1) exp_b.push_back({id, err ? 2'b10 : 2'b00});
    S_AWID = id; S_AWADDR = 32'(a0); S_AWLEN = 8'(len);
    S_AWSIZE = 3'(size); S_AWBURST = 2'(burst); S_AWVALID = 1'b1;
    wait_sig(0, "awready");
    S_AWVALID = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      S_WVALID = 1'b1; S_WDATA = wbuf[i]; S_WSTRB = sbuf[i];
      S_WLAST = (i == len);
      wait_sig(1, "wready");
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    if (nsend == len + 1) wait_sig(2, "bvalid");
  endtask

  task automatic do_read(input int a0, input int len, input int size,
                         input int burst, input logic [3:0] id,
                         input bit tog);
    bit lg, hit;
    int a, t;
    rbeat_t e;
    lg = legal_m(len, size, burst);
    rlog.delete();
    for (int i = 0; i <= len; i++) begin
      a = baddr(a0, len, size, burst, i);
      hit = lg && (a < MEMB);
      e.id = id;
      e.data = hit ? mword(a) : 64'h0;
      e.resp = hit ? 2'b00 : 2'b10;
      e.last = (i == len);
      exp_r.push_back(e);
    end
    S_ARID = id; S_ARADDR = 32'(a0); S_ARLEN = 8'(len);
    S_ARSIZE = 3'(size); S_ARBURST = 2'(burst); S_ARVALID = 1'b1;
    wait_sig(3, "arready");
    S_ARVALID = 1'b0;
    t = 0;
    while (exp_r.size() != 0 && t < 200) begin
      if (tog) S_RREADY = !S_RREADY;
      @(posedge ACLK);
      #1;
      t++;
    end
    check("r_drain", exp_r.size(), 0);
    S_RREADY = 1'b1;
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge ACLK) begin
    if (ARESET) begin
      check("rst_ctl", {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY,
                        S_RVALID, S_RLAST, S_BID, S_BRESP, S_RID,
                        S_RRESP, wr_done_cnt, rd_done_cnt}, 0);
      check("rst_rdata", S_RDATA, 0);
      check("node_id", node_id, 6'd27);
      exp_wr = 0;
      exp_rd = 0;
      stall = 0;
    end else begin
      check("wr_done_cnt", wr_done_cnt, exp_wr);
      check("rd_done_cnt", rd_done_cnt, exp_rd);
      if (stall) check("r_stable", {S_RVALID, S_RDATA}, {1'b1, stall_data});
      if (S_BVALID && S_BREADY) begin
        if (exp_b.size() == 0) check("b_unexpected", S_BVALID, 1'b0);
        else check("bresp", {S_BID, S_BRESP}, exp_b.pop_front());
        last_bresp = S_BRESP;
        exp_wr++;
      end
      if (S_RVALID && S_RREADY) begin
        if (exp_r.size() == 0) check("r_unexpected", S_RVALID, 1'b0);
        else check("rbeat", {S_RID, S_RDATA, S_RRESP, S_RLAST},
                   exp_r.pop_front());
        rlog.push_back(S_RDATA);
        if (S_RLAST) exp_rd++;
      end
      stall = S_RVALID && !S_RREADY;
      stall_data = S_RDATA;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEMB; i++) mb[i] = 8'h00;
    S_AWID = 0; S_AWADDR = 0; S_AWLEN = 0; S_AWSIZE = 0; S_AWBURST = 0;
    S_AWVALID = 0; S_WDATA = 0; S_WSTRB = 0; S_WLAST = 0; S_WVALID = 0;
    S_BREADY = 1; S_ARID = 0; S_ARADDR = 0; S_ARLEN = 0; S_ARSIZE = 0;
    S_ARBURST = 0; S_ARVALID = 0; S_RREADY = 1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_post_rst", S_AWREADY, 1'b1);
    check("arready_post_rst", S_ARREADY, 1'b1);
    @(posedge ACLK); #1;

    // INCR write/read of four beats
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'(8'h11 * (i + 1));
      sbuf[i] = 8'hFF;
    end
    do_write(32'h1000, 3, 3, 1, 4'h1, 4);
    check("t1_bresp", last_bresp, 2'b00);
    do_read(32'h1000, 3, 3, 1, 4'h2, 1'b0);
    check("t1_nbeats", rlog.size(), 4);
    check("t1_b0", rlog[0], 64'h11);
    check("t1_b3", rlog[3], 64'h44);
    @(negedge ACLK);
    check("t1_wcnt", wr_done_cnt, 16'd1);
    check("t1_rcnt", rd_done_cnt, 16'd1);
    @(posedge ACLK); #1;

    // partial strobe
    wbuf[0] = 64'hFACECAFEDEADBEEF; sbuf[0] = 8'h0F;
    do_write(32'h0008, 0, 3, 1, 4'h3, 1);
    do_read(32'h0008, 0, 3, 1, 4'h4, 1'b0);
    check("t2_strb", rlog[0], 64'h00000000DEADBEEF);

    // burst running off the top of memory
    wbuf[0] = 64'h55; wbuf[1] = 64'h66; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    do_write(32'h1FF8, 1, 3, 1, 4'h5, 2);
    check("t3_bresp", last_bresp, 2'b10);
    do_read(32'h1FF8, 0, 3, 1, 4'h6, 1'b0);
    check("t3_kept", rlog[0], 64'h55);

    // stalled 8-beat read
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
      sbuf[i] = 8'hFF;
    end
    do_write(32'h0200, 7, 3, 1, 4'h7, 8);
    do_read(32'h0200, 7, 3, 1, 4'h8, 1'b1);
    check("t4_nbeats", rlog.size(), 8);
    check("t4_b5", rlog[5], 64'hC0DE_0000_0000_0005);

    // WRAP read
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'hA0 + 64'(i);
      sbuf[i] = 8'hFF;
    end
    do_write(32'h0000, 3, 3, 1, 4'h9, 4);
    do_read(32'h0010, 3, 3, 2, 4'hA, 1'b0);
`ifdef AXI_BURST_WRAP_EN
    check("t5_b0", rlog[0], 64'hA2);
    check("t5_b2", rlog[2], 64'hA0);
`else
    check("t5_b0", rlog[0], 64'h0);
    check("t5_b2", rlog[2], 64'h0);
`endif

    // narrow INCR into one word
    wbuf[0] = 64'h0000_0000_1111_1111; sbuf[0] = 8'h0F;
    wbuf[1] = 64'h2222_2222_0000_0000; sbuf[1] = 8'hF0;
    do_write(32'h0700, 1, 2, 1, 4'hB, 2);
    do_read(32'h0700, 0, 3, 1, 4'hC, 1'b0);
    check("t6_narrow", rlog[0], 64'h2222_2222_1111_1111);

    // FIXED write, then FIXED read
    for (int i = 0; i < 3; i++) begin
      wbuf[i] = 64'hC0 + 64'(i);
      sbuf[i] = 8'hFF;
    end
    do_write(32'h0600, 2, 3, 0, 4'hD, 3);
    do_read(32'h0600, 1, 3, 0, 4'hE, 1'b0);
    check("t7_fixed", rlog[1], 64'hC2);

    // illegal size and burst type
    wbuf[0] = 64'hBAD; sbuf[0] = 8'hFF;
    do_write(32'h0500, 0, 4, 1, 4'hF, 1);
    check("t8_bresp", last_bresp, 2'b10);
    do_read(32'h0500, 0, 3, 1, 4'h1, 1'b0);
    check("t8_nowrite", rlog[0], 64'h0);
    do_read(32'h1000, 1, 3, 3, 4'h2, 1'b0);
    check("t8_burst3", rlog[0], 64'h0);

    // WRAP write
    wbuf[0] = 64'h99; wbuf[1] = 64'h9A; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    do_write(32'h0020, 1, 3, 2, 4'h3, 2);
`ifdef AXI_BURST_WRAP_EN
    check("t9_bresp", last_bresp, 2'b00);
`else
    check("t9_bresp", last_bresp, 2'b10);
`endif

    // reset in the middle of a write burst
    wbuf[0] = 64'hB0; wbuf[1] = 64'hB1; sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    do_write(32'h0400, 3, 3, 1, 4'h4, 2);
    ARESET = 1'b1;
    repeat (2) begin
      @(posedge ACLK); #1;
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    check("t10_awready", S_AWREADY, 1'b1);
    check("t10_bvalid", S_BVALID, 1'b0);
    check("t10_wcnt", wr_done_cnt, 16'd0);
    @(posedge ACLK); #1;
    do_read(32'h0400, 3, 3, 1, 4'h5, 1'b0);
    check("t10_b0", rlog[0], 64'hB0);
    check("t10_b1", rlog[1], 64'hB1);
    check("t10_b2", rlog[2], 64'h0);

    repeat (3) @(posedge ACLK);
    check("drain", exp_r.size() + exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
